// File: rtl/wb_bus_arbiter.sv
// Two-to-one round-robin Wishbone arbiter with a response watchdog.
// Shares one Wishbone master port between the instruction-fetch bus (ibus)
// and the load/store bus (dbus). A grant is held for a whole transaction.
// One idle cycle always separates consecutive grants.
module wb_bus_arbiter #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TO_W    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] ibus_adr,
    input  logic [3:0]  ibus_sel,
    input  logic        ibus_cyc,
    input  logic        ibus_stb,
    output logic [31:0] ibus_dat_miso,
    output logic        ibus_ack,
    output logic        ibus_err,
    input  logic [29:0] dbus_adr,
    input  logic [31:0] dbus_dat_mosi,
    input  logic [3:0]  dbus_sel,
    input  logic        dbus_cyc,
    input  logic        dbus_stb,
    input  logic        dbus_we,
    output logic [31:0] dbus_dat_miso,
    output logic        dbus_ack,
    output logic        dbus_err,
    output logic [29:0] wb_adr,
    output logic [31:0] wb_dat_mosi,
    output logic [3:0]  wb_sel,
    output logic        wb_cyc,
    output logic        wb_stb,
    output logic        wb_we,
    input  logic [31:0] wb_dat_miso,
    input  logic        wb_ack,
    input  logic        wb_err,
    output logic        timeout_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT_I = 2'd1,
        ST_GNT_D = 2'd2
    } state_e;

    // Watchdog is disabled entirely when TIMEOUT is zero.
    localparam bit            WD_EN   = (TIMEOUT != 32'd0);
    localparam logic [TO_W-1:0] TO_LAST = WD_EN ? TO_W'(TIMEOUT - 32'd1) : {TO_W{1'b0}};

    state_e          state_q, state_d;
    logic            last_q, last_d;       // 0 = ibus served last, 1 = dbus
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            timeout_q, timeout_d;

    logic ireq_s, dreq_s;
    logic gnt_i_s, gnt_d_s;
    logic resp_s, abort_s, fire_s;

    assign ireq_s  = ibus_cyc & ibus_stb;
    assign dreq_s  = dbus_cyc & dbus_stb;
    assign gnt_i_s = (state_q == ST_GNT_I);
    assign gnt_d_s = (state_q == ST_GNT_D);
    assign resp_s  = wb_ack | wb_err;
    // Granted master withdrawing its cycle ends the transaction without a response.
    assign abort_s = (gnt_i_s & ~ibus_cyc) | (gnt_d_s & ~dbus_cyc);
    // A slave response in the final cycle wins over the watchdog.
    assign fire_s  = WD_EN & (gnt_i_s | gnt_d_s) & (to_cnt_q == TO_LAST) & ~resp_s;

    assign timeout_o = timeout_q;

    // State register: grant state, round-robin pointer, watchdog counter and timeout pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            last_q    <= 1'b1;
            to_cnt_q  <= {TO_W{1'b0}};
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            to_cnt_q  <= to_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state logic: round-robin arbitration in IDLE, termination and watchdog counting in a grant.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        to_cnt_d  = to_cnt_q;
        timeout_d = fire_s;
        case (state_q)
            ST_IDLE: begin
                if (ireq_s && dreq_s) begin
                    state_d  = last_q ? ST_GNT_I : ST_GNT_D;
                    to_cnt_d = {TO_W{1'b0}};
                end else if (ireq_s) begin
                    state_d  = ST_GNT_I;
                    to_cnt_d = {TO_W{1'b0}};
                end else if (dreq_s) begin
                    state_d  = ST_GNT_D;
                    to_cnt_d = {TO_W{1'b0}};
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_GNT_I: begin
                if (resp_s || abort_s || fire_s) begin
                    state_d = ST_IDLE;
                    last_d  = 1'b0;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            ST_GNT_D: begin
                if (resp_s || abort_s || fire_s) begin
                    state_d = ST_IDLE;
                    last_d  = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            default: begin
                state_d  = ST_IDLE;
                last_d   = 1'b1;
                to_cnt_d = {TO_W{1'b0}};
            end
        endcase
    end

    // Output logic: route the granted master onto the shared bus and steer responses back to it.
    always_comb begin
        wb_adr        = 30'd0;
        wb_dat_mosi   = 32'd0;
        wb_sel        = 4'd0;
        wb_cyc        = 1'b0;
        wb_stb        = 1'b0;
        wb_we         = 1'b0;
        ibus_dat_miso = wb_dat_miso;
        dbus_dat_miso = wb_dat_miso;
        ibus_ack      = 1'b0;
        ibus_err      = 1'b0;
        dbus_ack      = 1'b0;
        dbus_err      = 1'b0;
        case (state_q)
            ST_GNT_I: begin
                wb_adr   = ibus_adr;
                wb_sel   = ibus_sel;
                wb_cyc   = ibus_cyc;
                wb_stb   = ibus_stb;
                ibus_ack = wb_ack;
                ibus_err = wb_err | fire_s;
            end
            ST_GNT_D: begin
                wb_adr      = dbus_adr;
                wb_dat_mosi = dbus_dat_mosi;
                wb_sel      = dbus_sel;
                wb_cyc      = dbus_cyc;
                wb_stb      = dbus_stb;
                wb_we       = dbus_we;
                dbus_ack    = wb_ack;
                dbus_err    = wb_err | fire_s;
            end
            default: begin
                wb_cyc = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/wb_bus_arbiter.md
Name: wb_bus_arbiter

Overview:
- Two-to-one Wishbone arbiter. It shares a single Wishbone master port between the CPU instruction-fetch bus (ibus) and the load/store bus (dbus).
- It sits between the Riskv core wrapper and a single-ported memory or interconnect.
- Arbitration is round-robin. A grant is held for a whole transaction.
- A bus watchdog terminates transactions that get no response.

Parameters:
TIMEOUT, 255, max cycles a granted transaction may wait for ACK/ERR before the arbiter forces ERR; 0 disables the watchdog
TO_W, 8, width of the watchdog counter; must satisfy TIMEOUT < 2**TO_W

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  asynchronous reset, active-high
ibus_adr  in  30  ibus word address
ibus_sel  in  4  ibus byte select
ibus_cyc  in  1  ibus cycle
ibus_stb  in  1  ibus strobe
ibus_dat_miso  out  32  read data to ibus
ibus_ack  out  1  ibus acknowledge
ibus_err  out  1  ibus error
dbus_adr  in  30  dbus word address
dbus_dat_mosi  in  32  dbus write data
dbus_sel  in  4  dbus byte select
dbus_cyc  in  1  dbus cycle
dbus_stb  in  1  dbus strobe
dbus_we  in  1  dbus write enable
dbus_dat_miso  out  32  read data to dbus
dbus_ack  out  1  dbus acknowledge
dbus_err  out  1  dbus error
wb_adr  out  30  shared bus word address
wb_dat_mosi  out  32  shared bus write data
wb_sel  out  4  shared bus byte select
wb_cyc  out  1  shared bus cycle
wb_stb  out  1  shared bus strobe
wb_we  out  1  shared bus write enable
wb_dat_miso  in  32  shared bus read data
wb_ack  in  1  shared bus acknowledge
wb_err  in  1  shared bus error
timeout_o  out  1  one-cycle pulse when the watchdog fires

Behaviour:
- Request definitions: ireq = ibus_cyc & ibus_stb; dreq = dbus_cyc & dbus_stb.
- States: IDLE, GNT_I, GNT_D. State, the last-grant pointer `last` (0 = ibus, 1 = dbus) and the counter `to_cnt` are registered.
- Reset, asserted asynchronously: state = IDLE, last = 1 (so ibus wins the first tie), to_cnt = 0, timeout_o = 0.
  - The combinational outputs below then evaluate to: all wb_* outputs 0, all ack/err outputs 0.
  - ibus_dat_miso and dbus_dat_miso stay the wb_dat_miso pass-through.
- IDLE transitions:
  - ireq only -> GNT_I.
  - dreq only -> GNT_D.
  - Both -> grant the side not equal to `last`.
  - Neither -> stay in IDLE.
  - The grant register updates at the clock edge. Latency from request to wb_cyc is therefore exactly 1 cycle.
  - to_cnt is cleared on entering any GNT state.
- Shared-bus outputs:
  - In GNT_x: wb_adr, wb_sel, wb_cyc and wb_stb are routed combinationally from bus x.
  - wb_dat_mosi and wb_we come from dbus in GNT_D; they are 0 in GNT_I.
  - In IDLE all wb_* outputs are 0.
- Response routing:
  - ibus_dat_miso = dbus_dat_miso = wb_dat_miso (broadcast).
  - ibus_ack = wb_ack & GNT_I; ibus_err = (wb_err & GNT_I) | (watchdog fire & GNT_I).
  - dbus_ack and dbus_err are the same with GNT_D.
  - The non-granted master never sees ack or err.
- Leaving a GNT state goes to IDLE on any of:
  - wb_ack or wb_err: set `last` to the granted side.
  - Granted master drops cyc (abort): `last` is set as above; no ack is generated.
  - Watchdog fire: `last` is set as above.
- Idle gap: one IDLE cycle is mandatory between transactions. wb_cyc is therefore guaranteed low for at least 1 cycle between grants, and no back-to-back grant is possible.
- Watchdog:
  - In a GNT state with no ack/err, to_cnt increments by 1 each cycle.
  - Fire condition: TIMEOUT != 0, to_cnt == TIMEOUT-1, and no wb_ack/wb_err in that cycle.
  - On fire: a combinational ERR to the granted master that same cycle, and timeout_o = 1 on the next cycle (registered, 1 cycle wide).
  - A wb_ack in the firing cycle takes precedence, and no timeout occurs.
  - A transaction held TIMEOUT cycles without response therefore gets its ERR in cycle TIMEOUT after the grant edge.
- Simultaneous events:
  - A new request from the non-granted side during a grant is ignored until IDLE. It is served next, since `last` now points away from it.
  - A request asserted while its own side's transaction is terminating is re-arbitrated in IDLE normally.
- Reset mid-transaction:
  - wb_cyc and wb_stb drop immediately (asynchronously).
  - No ack or err is issued to either master.

Test Plan:
- ibus only, ireq at cycle 0, slave acks in cycle 3 -> wb_cyc rises cycle 1, wb_adr = ibus_adr, ibus_ack = 1 in cycle 3, wb_cyc = 0 in cycle 4, dbus_ack stays 0.
- ireq and dreq asserted together from reset, each acked after 2 cycles -> order is ibus, IDLE, dbus, IDLE; wb_we follows dbus_we only in GNT_D.
- dbus write with dat_mosi = 0xDEADBEEF, sel = 4'b0011, while ibus requests continuously -> strict alternation i/d/i/d over 8 transactions; wb_dat_mosi = 0xDEADBEEF and wb_we = 1 only during dbus grants.
- TIMEOUT = 4, slave never acks a dbus read -> dbus_err pulse in cycle 4 after the grant, timeout_o = 1 next cycle, wb_cyc = 0, next ibus request is granted.
- Assert reset mid-grant (GNT_D, cycle 2) -> wb_cyc, wb_stb and ack/err drop in the same cycle; after release ibus wins the first tie.
- Granted ibus drops cyc before ack, wb_err injected on a dbus transaction -> ibus grant aborts with no ack; dbus_err = 1, ibus_err = 0.
